mem_port_arbiter: RTL and testbench

- Arbitrates one single-port unified memory between two requesters of the 5-stage pipeline: instruction fetch (IF, read-only) and data access (MEM stage, read/write).
- Sequences each access through a request/ready handshake to the backing RAM.
- Returns read data plus a one-cycle ack to the winning requester.
- Drives a pipeline stall while any request is outstanding, and guards against a hung RAM with a timeout.

---
 rtl/mem_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified RAM between the IF
// (read-only) and MEM (read/write) pipeline stages.
// Each access is one request/ready handshake to the RAM. The winning
// requester gets registered read data and a one-cycle ack. A saturating
// wait counter aborts a stuck access after WAIT_MAX busy cycles and sets a
// sticky timeout flag.
// Optional macro ARB_RR_EN: round-robin between IF and MEM when both
// request at once. When it is undefined, MEM always wins (the older
// instruction goes first).
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15   // 1..255
) (
  input  logic              clk_i,
  input  logic              rst_i,        // asynchronous, active low
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_ready_i,
  output logic              stall_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  // last_grant encoding: the reset value 0 means MEM was granted last.
  localparam logic LG_MEM = 1'b0;
  localparam logic LG_IF  = 1'b1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic [7:0]        r_cnt;
  logic              r_if_ack;
  logic              r_mem_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_ram_req;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_timeout;

  logic w_if_req_m;
  logic w_mem_req_m;
  logic w_pick_mem;
  logic w_cnt_expired;
  logic w_grant_if;
  logic w_grant_mem;
  logic w_done;
  logic w_abort;

  // A requester whose ack is showing this cycle has already been served.
  // Its request is masked so that it is not granted a second time.
  assign w_if_req_m  = if_req_i  & ~r_if_ack;
  assign w_mem_req_m = mem_req_i & ~r_mem_ack;

`ifdef ARB_RR_EN
  // On a tie, the requester that was not granted last wins.
  assign w_pick_mem = w_mem_req_m & (~w_if_req_m | (r_last_grant == LG_IF));
`else
  // Fixed priority: MEM holds the older instruction, so it always wins.
  assign w_pick_mem = w_mem_req_m;
`endif

  // The edge that ends the WAIT_MAX-th busy cycle without ready aborts.
  assign w_cnt_expired = (int'(r_cnt) + 1) >= WAIT_MAX;

  // Next-state and per-cycle control decode.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so
    // no path leaves one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_mem) begin
          w_state_nxt = BUSY_MEM;
          w_grant_mem = 1'b1;
        end else if (w_if_req_m) begin
          w_state_nxt = BUSY_IF;
          w_grant_if  = 1'b1;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (ram_ready_i) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end else if (w_cnt_expired) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples values from before the edge.
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Wait counter and grant history. The counter clears on a grant and
  // saturates rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt        <= '0;
      r_last_grant <= LG_MEM;
    end else if (w_grant_mem || w_grant_if) begin
      r_cnt        <= '0;
      r_last_grant <= w_grant_mem ? LG_MEM : LG_IF;
    end else if (r_state != IDLE && r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // RAM command registers. They latch on a grant, hold steady while busy,
  // and drop the request when the access completes or aborts.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else if (w_grant_mem) begin
      r_ram_req   <= 1'b1;
      r_ram_we    <= mem_we_i;
      r_ram_addr  <= mem_addr_i;
      r_ram_wdata <= mem_wdata_i;
    end else if (w_grant_if) begin
      r_ram_req   <= 1'b1;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= if_addr_i;
      r_ram_wdata <= '0;
    end else if (w_done || w_abort) begin
      r_ram_req   <= 1'b0;
    end
  end

  // Completion: one-cycle acks, captured read data, and the sticky timeout
  // flag. An aborted access returns zero data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_if_ack  <= (w_done || w_abort) && (r_state == BUSY_IF);
      r_mem_ack <= (w_done || w_abort) && (r_state == BUSY_MEM);
      if (r_state == BUSY_IF) begin
        if (w_done)       r_if_rdata <= ram_rdata_i;
        else if (w_abort) r_if_rdata <= '0;
      end
      if (r_state == BUSY_MEM) begin
        if (w_done && !r_ram_we) r_mem_rdata <= ram_rdata_i;
        else if (w_abort)        r_mem_rdata <= '0;
      end
      if (w_abort) r_timeout <= 1'b1;
    end
  end

  assign if_ack_o    = r_if_ack;
  assign mem_ack_o   = r_mem_ack;
  assign if_rdata_o  = r_if_rdata;
  assign mem_rdata_o = r_mem_rdata;
  assign ram_req_o   = r_ram_req;
  assign ram_we_o    = r_ram_we;
  assign ram_addr_o  = r_ram_addr;
  assign ram_wdata_o = r_ram_wdata;
  assign timeout_o   = r_timeout;

  // The pipeline stalls while any request is still waiting for its ack.
  assign stall_o = (if_req_i & ~r_if_ack) | (mem_req_i & ~r_mem_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios for mem_port_arbiter. The bench
// drives and samples 1 ns after each rising clock edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int WAIT_MAX = 15;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_ack_o;
  logic              ram_req_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;
  logic              ram_ready_i;
  logic              stall_o;
  logic              timeout_o;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .if_ack_o   (if_ack_o),
    .mem_req_i  (mem_req_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .mem_ack_o  (mem_ack_o),
    .ram_req_o  (ram_req_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i),
    .ram_ready_i(ram_ready_i),
    .stall_o    (stall_o),
    .timeout_o  (timeout_o)
  );

  // 10 ns clock.
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b0;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    ram_rdata_i = '0;
    ram_ready_i = 1'b0;
    step();
    step();
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ram_req_o !== 1'b0) begin failures++; $display("FAIL reset_ram_req got=%b exp=0", ram_req_o); end
    checks++; if (ram_we_o !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we_o); end
    checks++; if (ram_addr_o !== 32'h0 || ram_wdata_o !== 32'h0) begin failures++; $display("FAIL reset_ram_bus got=%h/%h exp=0/0", ram_addr_o, ram_wdata_o); end
    checks++; if (if_ack_o !== 1'b0 || mem_ack_o !== 1'b0) begin failures++; $display("FAIL reset_acks got=%b%b exp=00", if_ack_o, mem_ack_o); end
    checks++; if (if_rdata_o !== 32'h0 || mem_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata_o, mem_rdata_o); end
    checks++; if (timeout_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", timeout_o, stall_o); end
  endtask

  task automatic test_if_read();
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    #0;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL ifrd_stall_req got=%b exp=1", stall_o); end
    step();  // grant edge
    checks++; if (ram_req_o !== 1'b1 || ram_addr_o !== 32'h40 || ram_we_o !== 1'b0) begin failures++; $display("FAIL ifrd_grant got req=%b addr=%h we=%b exp req=1 addr=40 we=0", ram_req_o, ram_addr_o, ram_we_o); end
    checks++; if (if_ack_o !== 1'b0) begin failures++; $display("FAIL ifrd_early_ack got=%b exp=0", if_ack_o); end
    ram_ready_i = 1'b1;
    ram_rdata_i = 32'hDEADBEEF;
    step();  // completion edge
    checks++; if (if_ack_o !== 1'b1 || if_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL ifrd_ack got ack=%b data=%h exp ack=1 data=deadbeef", if_ack_o, if_rdata_o); end
    checks++; if (ram_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL ifrd_release got req=%b stall=%b exp 0 0", ram_req_o, stall_o); end
    if_req_i    = 1'b0;
    ram_ready_i = 1'b0;
    step();
    checks++; if (if_ack_o !== 1'b0 || ram_req_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL ifrd_after got ack=%b req=%b stall=%b exp 000", if_ack_o, ram_req_o, stall_o); end
  endtask

  task automatic test_mem_read();
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h180;
    step();
    checks++; if (ram_req_o !== 1'b1 || ram_addr_o !== 32'h180 || ram_we_o !== 1'b0) begin failures++; $display("FAIL memrd_grant got req=%b addr=%h we=%b exp 1 180 0", ram_req_o, ram_addr_o, ram_we_o); end
    ram_ready_i = 1'b1;
    ram_rdata_i = 32'hCAFEF00D;
    step();
    checks++; if (mem_ack_o !== 1'b1 || mem_rdata_o !== 32'hCAFEF00D || if_ack_o !== 1'b0) begin failures++; $display("FAIL memrd_ack got ack=%b data=%h ifack=%b exp 1 cafef00d 0", mem_ack_o, mem_rdata_o, if_ack_o); end
    mem_req_i   = 1'b0;
    ram_ready_i = 1'b0;
    step();
  endtask

  task automatic test_mem_write();
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_addr_i  = 32'h100;
    mem_wdata_i = 32'h12345678;
    ram_rdata_i = 32'h0BAD0BAD;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (ram_req_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 32'h100 || ram_wdata_o !== 32'h12345678 || mem_ack_o !== 1'b0) begin failures++; $display("FAIL memwr_hold%0d got req=%b we=%b addr=%h wd=%h ack=%b exp 1 1 100 12345678 0", i, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, mem_ack_o); end
      if (i == 2) ram_ready_i = 1'b1;
      step();
    end
    checks++; if (mem_ack_o !== 1'b1 || ram_req_o !== 1'b0) begin failures++; $display("FAIL memwr_ack got ack=%b req=%b exp 1 0", mem_ack_o, ram_req_o); end
    checks++; if (mem_rdata_o !== 32'hCAFEF00D) begin failures++; $display("FAIL memwr_rdata_kept got=%h exp=cafef00d", mem_rdata_o); end
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    ram_ready_i = 1'b0;
    step();
    checks++; if (mem_ack_o !== 1'b0 || ram_req_o !== 1'b0) begin failures++; $display("FAIL memwr_after got ack=%b req=%b exp 0 0", mem_ack_o, ram_req_o); end
  endtask

  task automatic test_simultaneous();
    logic first_is_mem;
`ifdef ARB_RR_EN
    first_is_mem = 1'b0;  // last_grant is MEM after reset, so IF goes first
`else
    first_is_mem = 1'b1;
`endif
    do_reset();
    if_req_i   = 1'b1;
    if_addr_i  = 32'h80;
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h200;
    step();
    checks++; if (ram_req_o !== 1'b1 || ram_addr_o !== (first_is_mem ? 32'h200 : 32'h80)) begin failures++; $display("FAIL sim_first_grant got req=%b addr=%h exp req=1 addr=%h", ram_req_o, ram_addr_o, first_is_mem ? 32'h200 : 32'h80); end
    ram_ready_i = 1'b1;
    ram_rdata_i = 32'h11112222;
    step();
    checks++; if (mem_ack_o !== first_is_mem || if_ack_o !== !first_is_mem) begin failures++; $display("FAIL sim_first_ack got mem=%b if=%b exp mem=%b", mem_ack_o, if_ack_o, first_is_mem); end
    checks++; if (stall_o !== 1'b1 || ram_req_o !== 1'b0) begin failures++; $display("FAIL sim_mid got stall=%b req=%b exp 1 0", stall_o, ram_req_o); end
    // The served requester keeps its request high through its ack cycle;
    // the masking must hand the next grant to the other one.
    ram_ready_i = 1'b0;
    step();
    checks++; if (ram_req_o !== 1'b1 || ram_addr_o !== (first_is_mem ? 32'h80 : 32'h200)) begin failures++; $display("FAIL sim_second_grant got req=%b addr=%h exp req=1 addr=%h", ram_req_o, ram_addr_o, first_is_mem ? 32'h80 : 32'h200); end
    if (first_is_mem) mem_req_i = 1'b0;
    else              if_req_i  = 1'b0;
    ram_ready_i = 1'b1;
    ram_rdata_i = 32'h33334444;
    step();
    checks++; if (mem_ack_o !== !first_is_mem || if_ack_o !== first_is_mem) begin failures++; $display("FAIL sim_second_ack got mem=%b if=%b exp if=%b", mem_ack_o, if_ack_o, first_is_mem); end
    checks++; if ((first_is_mem ? if_rdata_o : mem_rdata_o) !== 32'h33334444) begin failures++; $display("FAIL sim_second_data got if=%h mem=%h exp 33334444", if_rdata_o, mem_rdata_o); end
    if_req_i    = 1'b0;
    mem_req_i   = 1'b0;
    ram_ready_i = 1'b0;
    step();
    checks++; if (ram_req_o !== 1'b0 || if_ack_o !== 1'b0 || mem_ack_o !== 1'b0) begin failures++; $display("FAIL sim_no_regrant got req=%b ifack=%b memack=%b exp 000", ram_req_o, if_ack_o, mem_ack_o); end
  endtask

  task automatic test_timeout();
    int busy;
    logic early_ack;
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h300;
    ram_ready_i = 1'b0;
    step();
    busy      = 0;
    early_ack = 1'b0;
    while (ram_req_o === 1'b1 && busy < 40) begin
      if (mem_ack_o !== 1'b0) early_ack = 1'b1;
      busy++;
      step();
    end
    checks++; if (busy !== WAIT_MAX) begin failures++; $display("FAIL to_busy_cycles got=%0d exp=%0d", busy, WAIT_MAX); end
    checks++; if (early_ack !== 1'b0) begin failures++; $display("FAIL to_early_ack got=%b exp=0", early_ack); end
    checks++; if (mem_ack_o !== 1'b1 || mem_rdata_o !== 32'h0 || timeout_o !== 1'b1) begin failures++; $display("FAIL to_abort got ack=%b data=%h to=%b exp 1 0 1", mem_ack_o, mem_rdata_o, timeout_o); end
    mem_req_i = 1'b0;
    step();
    // A later successful access leaves the flag set.
    if_req_i  = 1'b1;
    if_addr_i = 32'h44;
    step();
    ram_ready_i = 1'b1;
    ram_rdata_i = 32'h55AA55AA;
    step();
    checks++; if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h55AA55AA || timeout_o !== 1'b1) begin failures++; $display("FAIL to_sticky got ack=%b data=%h to=%b exp 1 55aa55aa 1", if_ack_o, if_rdata_o, timeout_o); end
    if_req_i    = 1'b0;
    ram_ready_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic late_ack;
    if_req_i  = 1'b1;
    if_addr_i = 32'h48;
    step();
    checks++; if (ram_req_o !== 1'b1 || timeout_o !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got req=%b to=%b exp 1 1", ram_req_o, timeout_o); end
    #2;
    rst_i = 1'b0;
    #1;
    checks++; if (ram_req_o !== 1'b0 || if_ack_o !== 1'b0 || timeout_o !== 1'b0) begin failures++; $display("FAIL rst_mid_async got req=%b ack=%b to=%b exp 000", ram_req_o, if_ack_o, timeout_o); end
    if_req_i    = 1'b0;
    ram_ready_i = 1'b1;  // a stray ready in IDLE is ignored
    step();
    rst_i = 1'b1;
    late_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (if_ack_o !== 1'b0 || mem_ack_o !== 1'b0 || ram_req_o !== 1'b0) late_ack = 1'b1;
    end
    checks++; if (late_ack !== 1'b0) begin failures++; $display("FAIL rst_mid_no_ack got=%b exp=0", late_ack); end
    ram_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_mem_read();
    test_mem_write();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
